// File: rtl/vga_timing_monitor.sv
// rtl/vga_timing_monitor.sv - recovers col/row from porch-shaped syncs and checks 800x600 geometry
// Optional error counter built when VGA_MON_STATS_EN is defined.
module vga_timing_monitor #(
    parameter int   DISP_COLS    = 800,
    parameter int   DISP_ROWS    = 600,
    parameter int   TOTAL_COLS   = 1040,
    parameter int   TOTAL_ROWS   = 666,
    parameter int   H_SYNC_PULSE = 120,
    parameter int   H_BACK_PORCH = 64,
    parameter int   V_SYNC_PULSE = 6,
    parameter int   V_BACK_PORCH = 23,
    parameter logic SYNC_ACTIVE  = 1'b0,
    parameter int   LOCK_FRAMES  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        h_sync_with_porch,
    input  logic        v_sync_with_porch,
    output logic [10:0] col,
    output logic [9:0]  row,
    output logic        frame_start,
    output logic        disp_active,
    output logic        locked,
    output logic        err_line,
    output logic        err_frame,
    output logic [15:0] err_count
);

    localparam logic [10:0] COL_LAST  = 11'(TOTAL_COLS - 1);
    localparam logic [9:0]  ROW_LAST  = 10'(TOTAL_ROWS - 1);
    localparam logic [10:0] COL_MAX   = 11'd2047;
    localparam logic [9:0]  ROW_MAX   = 10'd1023;
    localparam logic [10:0] H_START   = 11'(H_SYNC_PULSE + H_BACK_PORCH);
    localparam logic [10:0] H_END     = 11'(H_SYNC_PULSE + H_BACK_PORCH + DISP_COLS);
    localparam logic [9:0]  V_START   = 10'(V_SYNC_PULSE + V_BACK_PORCH);
    localparam logic [9:0]  V_END     = 10'(V_SYNC_PULSE + V_BACK_PORCH + DISP_ROWS);
    localparam logic [7:0]  LOCK_GOOD = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    state_t     state;
    logic [7:0] good;
    logic       s_h, s_v, s_h_d, s_v_d;
    logic       v_pending;
    logic       h_edge, v_edge, frame_edge;
    logic       line_bad, frame_bad;

    assign h_edge     = (s_h == SYNC_ACTIVE) && (s_h_d != SYNC_ACTIVE);
    assign v_edge     = (s_v == SYNC_ACTIVE) && (s_v_d != SYNC_ACTIVE);
    assign frame_edge = h_edge && (v_pending || v_edge);

    // Saturation is flagged only on the 2046->2047 step so a lost sync reports once.
    assign line_bad  = (state != SEARCH) &&
                       ((h_edge && (col != COL_LAST)) || (!h_edge && (col == COL_MAX - 11'd1)));
    assign frame_bad = (state != SEARCH) && frame_edge && (row != ROW_LAST);

    assign disp_active = locked && (col >= H_START) && (col < H_END) &&
                         (row >= V_START) && (row < V_END);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_h       <= ~SYNC_ACTIVE;
            s_v       <= ~SYNC_ACTIVE;
            s_h_d     <= ~SYNC_ACTIVE;
            s_v_d     <= ~SYNC_ACTIVE;
            v_pending <= 1'b0;
            col       <= '0;
            row       <= '0;
            frame_start <= 1'b0;
            err_line  <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            s_h   <= h_sync_with_porch;
            s_v   <= v_sync_with_porch;
            s_h_d <= s_h;
            s_v_d <= s_v;

            if (h_edge)
                v_pending <= 1'b0;
            else if (v_edge)
                v_pending <= 1'b1;

            if (h_edge)
                col <= '0;
            else if (col != COL_MAX)
                col <= col + 11'd1;

            if (frame_edge)
                row <= '0;
            else if (h_edge && (row != ROW_MAX))
                row <= row + 10'd1;

            frame_start <= frame_edge;
            err_line    <= line_bad;
            err_frame   <= frame_bad;
        end
    end

    // FSM reacts to the registered pulses, so locked drops the cycle after an error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= SEARCH;
            good   <= '0;
            locked <= 1'b0;
        end else if (err_line) begin
            state  <= SEARCH;
            good   <= '0;
            locked <= 1'b0;
        end else if (err_frame) begin
            state  <= TRACK;
            good   <= '0;
            locked <= 1'b0;
        end else if (frame_start) begin
            case (state)
                SEARCH: begin
                    state <= TRACK;
                    good  <= '0;
                end
                TRACK: begin
                    if (good + 8'd1 >= LOCK_GOOD) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end else begin
                        good <= good + 8'd1;
                    end
                end
                default: begin
                    state  <= LOCKED;
                    locked <= 1'b1;
                end
            endcase
        end
    end

`ifdef VGA_MON_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            err_count <= '0;
        else if ((err_line || err_frame) && (err_count != 16'hFFFF))
            err_count <= err_count + 16'd1;
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb/tb_vga_timing_monitor.sv - scoreboard bench for vga_timing_monitor on a scaled geometry
module tb_vga_timing_monitor;

    localparam int TC = 40, HS = 4, HBP = 4, DC = 24;
    localparam int TR = 12, VS = 2, VBP = 2, DR = 6;

    logic        clk = 1'b0;
    logic        rst_n, h_sync, v_sync;
    logic [10:0] col;
    logic [9:0]  row;
    logic        frame_start, disp_active, locked, err_line, err_frame;
    logic [15:0] err_count;

    vga_timing_monitor #(
        .DISP_COLS(DC), .DISP_ROWS(DR), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
        .H_SYNC_PULSE(HS), .H_BACK_PORCH(HBP), .V_SYNC_PULSE(VS), .V_BACK_PORCH(VBP),
        .SYNC_ACTIVE(1'b0), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .h_sync_with_porch(h_sync), .v_sync_with_porch(v_sync),
        .col(col), .row(row), .frame_start(frame_start), .disp_active(disp_active),
        .locked(locked), .err_line(err_line), .err_frame(err_frame), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   due;
        int   row;
        logic fs;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_assert = 0, n_fail = 0;
    int   el_cnt = 0, ef_cnt = 0, el_cyc = -1, ef_cyc = -1;
    int   rise_cyc = -1, fall_cyc = -1, da_cnt = 0;
    int   fs_due = 0, last_due = 0, short_next_due = 0;
    logic prev_locked = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("sb_col", 32'(col), 0);
            chk("sb_row", 32'(row), e.row);
            chk("sb_frame_start", 32'(frame_start), 32'(e.fs));
        end
        if (err_line)  begin el_cnt++; el_cyc = cyc; end
        if (err_frame) begin ef_cnt++; ef_cyc = cyc; end
        if (disp_active) da_cnt++;
        if (locked && !prev_locked) rise_cyc = cyc;
        if (!locked && prev_locked) fall_cyc = cyc;
        prev_locked = locked;
    end

    // Lines are TC clocks (short_idx line is TC-1); v leads h by lead clocks at frame edges.
    task automatic drive_frame(input int nlines, input int short_idx, input int lead_in, input int lead_out);
        for (int l = 0; l < nlines; l++) begin
            int len;
            len = (l == short_idx) ? TC - 1 : TC;
            for (int c = 0; c < len; c++) begin
                logic vlow;
                vlow = ((l < VS) && !((l == VS - 1) && (c >= len - lead_in))) ||
                       ((l == nlines - 1) && (lead_out > 0) && (c >= len - lead_out));
                h_sync = (c < HS) ? 1'b0 : 1'b1;
                v_sync = ~vlow;
                if (c == 0) begin
                    sb.push_back('{due: cyc + 2, row: l, fs: (l == 0)});
                    last_due = cyc + 2;
                    if (l == 0) fs_due = cyc + 2;
                    if (short_idx >= 0 && l == short_idx + 1) short_next_due = cyc + 2;
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic idle(input int n);
        h_sync = 1'b1;
        v_sync = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_col"}, 32'(col), 0);
        chk({tag, "_row"}, 32'(row), 0);
        chk({tag, "_frame_start"}, 32'(frame_start), 0);
        chk({tag, "_disp_active"}, 32'(disp_active), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_err_line"}, 32'(err_line), 0);
        chk({tag, "_err_frame"}, 32'(err_frame), 0);
        chk({tag, "_err_count"}, 32'(err_count), 0);
    endtask

    initial begin
        int fs3, sat_due;
        rst_n = 1'b0;
        h_sync = 1'b1;
        v_sync = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Nominal: lock after the third frame start, full active window once locked.
        da_cnt = 0;
        drive_frame(TR, -1, 0, 0);
        drive_frame(TR, -1, 0, 0);
        chk("nom_unlocked_da", da_cnt, 0);
        chk("nom_unlocked", 32'(locked), 0);
        da_cnt = 0;
        drive_frame(TR, -1, 0, 0);
        fs3 = fs_due;
        chk("nom_lock_rise", rise_cyc, fs3 + 1);
        chk("nom_da_frame3", da_cnt, DC * DR);
        da_cnt = 0;
        drive_frame(TR, -1, 0, 0);
        chk("nom_da_frame4", da_cnt, DC * DR);
        chk("nom_locked", 32'(locked), 1);
        chk("nom_err_line", el_cnt, 0);
        chk("nom_err_frame", ef_cnt, 0);

        // Short line while locked.
        drive_frame(TR, 5, 0, 0);
        chk("short_err_line_cnt", el_cnt, 1);
        chk("short_err_line_cyc", el_cyc, short_next_due);
        chk("short_lock_fall", fall_cyc, short_next_due + 1);
        drive_frame(TR, -1, 0, 0);
        drive_frame(TR, -1, 0, 0);
        chk("short_still_unlocked", 32'(locked), 0);
        drive_frame(TR, -1, 0, 0);
        chk("short_relock", rise_cyc, fs_due + 1);
        chk("short_err_frame_cnt", ef_cnt, 0);

        // Long frame while locked: back to TRACK, two clean frame starts relock.
        drive_frame(TR + 1, -1, 0, 0);
        chk("long_no_err_yet", ef_cnt, 0);
        drive_frame(TR, -1, 0, 0);
        chk("long_err_frame_cnt", ef_cnt, 1);
        chk("long_err_frame_cyc", ef_cyc, fs_due);
        chk("long_lock_fall", fall_cyc, fs_due + 1);
        drive_frame(TR, -1, 0, 0);
        chk("long_unlocked", 32'(locked), 0);
        drive_frame(TR, -1, 0, 0);
        chk("long_relock", rise_cyc, fs_due + 1);
        chk("long_err_line_cnt", el_cnt, 1);

        // v sync leading h sync by 5 clocks.
        drive_frame(TR, -1, 0, 5);
        drive_frame(TR, -1, 5, 5);
        drive_frame(TR, -1, 5, 0);
        chk("skew_locked", 32'(locked), 1);
        chk("skew_err_line", el_cnt, 1);
        chk("skew_err_frame", ef_cnt, 1);

        // Lost sync: col saturates with exactly one err_line.
        sat_due = last_due + 2047;
        idle(2100);
        chk("lost_col_sat", 32'(col), 2047);
        chk("lost_err_line_cnt", el_cnt, 2);
        chk("lost_err_line_cyc", el_cyc, sat_due);
        chk("lost_lock_fall", fall_cyc, sat_due + 1);
        chk("lost_unlocked", 32'(locked), 0);

        // Resync, then reset in the middle of a frame.
        drive_frame(TR, -1, 0, 0);
        drive_frame(6, -1, 0, 0);
        chk("mid_row", 32'(row), 5);
        rst_n = 1'b0;
        h_sync = 1'b1;
        v_sync = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("mid_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Three short lines, each seen from TRACK.
        drive_frame(TR, -1, 0, 0);
        drive_frame(TR, 3, 0, 0);
        drive_frame(TR, 3, 0, 0);
        drive_frame(TR, 3, 0, 0);
        drive_frame(2, -1, 0, 0);
        chk("stats_err_line_cnt", el_cnt, 5);
`ifdef VGA_MON_STATS_EN
        chk("stats_err_count", 32'(err_count), 3);
`else
        chk("stats_err_count", 32'(err_count), 0);
`endif
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_monitor.md
Name: vga_timing_monitor

Overview:
- Receive-side counterpart to the VGA sync generator. Consumes the porch-shaped h_sync/v_sync that the top level drives to the connector, and recovers col/row position from them.
- Checks line and frame geometry against the 800x600 timing parameters and reports lock, active-display and error status.
- Sits beside the top level as an in-system loopback checker, or at the input of a downstream pixel consumer.

Parameters:
- DISP_COLS, 800, active columns per line
- DISP_ROWS, 600, active rows per frame
- TOTAL_COLS, 1040, clocks per line, sync edge to sync edge
- TOTAL_ROWS, 666, lines per frame
- H_SYNC_PULSE, 120, h sync width in clocks
- H_BACK_PORCH, 64, clocks from h sync end to first active column
- V_SYNC_PULSE, 6, v sync width in lines
- V_BACK_PORCH, 23, lines from v sync end to first active row
- SYNC_ACTIVE, 1'b0, asserted level of both sync inputs
- LOCK_FRAMES, 2, consecutive clean frames required to declare lock

Ports:
- clk  in  1  pixel clock; same clock that generates the syncs
- rst_n  in  1  synchronous active-low reset
- h_sync_with_porch  in  1  horizontal sync under test
- v_sync_with_porch  in  1  vertical sync under test
- col  out  11  column count; 0 = first clock of h sync pulse
- row  out  10  row count; 0 = line carrying the v sync start
- frame_start  out  1  1-cycle pulse when row and col both return to 0
- disp_active  out  1  locked and (col,row) inside the active window
- locked  out  1  geometry verified
- err_line  out  1  1-cycle pulse on bad line length
- err_frame  out  1  1-cycle pulse on bad frame length
- err_count  out  16  saturating error count (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, state SEARCH, sync sample registers loaded with the inactive level, v_pending=0. Reset wins over everything, including mid-frame.
- Input sampling: each sync is registered once (s_h, s_v) and again (s_h_d, s_v_d).
  - h_edge = (s_h==SYNC_ACTIVE) && (s_h_d!=SYNC_ACTIVE); v_edge is formed the same way.
  - Latency: col=0 appears 2 clocks after h sync first asserts at the input.
- col: on h_edge, col<=0; otherwise col<=col+1, saturating at 2047.
- v_pending: v_edge sets it; the next h_edge (or the same cycle) consumes it. This tolerates v/h skew.
- row, on h_edge:
  - with v_pending or v_edge: row<=0, frame_start pulses the same cycle col goes to 0.
  - otherwise: row<=row+1, saturating at 1023.
- Line check, on h_edge when state!=SEARCH: col!=TOTAL_COLS-1 pulses err_line the next cycle. col saturating at 2047 also pulses err_line, once per saturation.
- Frame check, at frame start when state!=SEARCH: row!=TOTAL_ROWS-1 pulses err_frame.
- FSM:
  - SEARCH: first frame start -> TRACK, good=0; no checks performed.
  - TRACK: clean frame start -> good+1; reaching LOCK_FRAMES -> LOCKED.
  - LOCKED: locked=1.
  - err_line in TRACK/LOCKED -> SEARCH.
  - err_frame -> TRACK with good=0, because the edge is still a valid frame start.
  - locked falls the cycle after the error pulse.
- disp_active is combinational from the registered counters, aligned with col/row:
  - locked
  - && col in [H_SYNC_PULSE+H_BACK_PORCH, +DISP_COLS), i.e. 184..983
  - && row in [V_SYNC_PULSE+V_BACK_PORCH, +DISP_ROWS), i.e. 29..628
- Simultaneous err_line and err_frame: both pulse; the FSM goes to SEARCH.

Optional Feature:
- Macro: VGA_MON_STATS_EN.
- Defined: err_count increments by 1 per cycle with err_line or err_frame (by 1 total if both), saturates at 16'hFFFF, and clears only on reset.
- Undefined: err_count is tied to 0 and no counter logic is built.

Test Plan:
- Nominal: drive ideal 1040x666 timing, 120/6 sync widths, active-low -> locked rises at the 3rd frame start (LOCK_FRAMES=2); no error pulses; disp_active high 800 clocks per line for rows 29..628.
- Latency: h sync asserts at clock T -> col=0 at T+2; frame_start coincides on the v-aligned line; row=0 there.
- Short line: once locked, one line of 1039 clocks -> err_line pulse, locked falls next cycle, FSM in SEARCH, relock after 3 frame starts.
- Long frame: a 667-line frame while locked -> err_frame, locked=0, state TRACK; 2 clean frames later locked=1.
- Skew: v sync leads h sync by 5 clocks -> row resets on the following h_edge with no errors; a lost sync lets col saturate at 2047 with a single err_line.
- Reset mid-frame at row 300: all outputs 0 next cycle; with VGA_MON_STATS_EN, err_count=0 after reset and equals 3 after 3 injected short lines.
